// File: rtl/axi_fifo_pkg.sv
// Shared AXI read-side definitions: response codes and read-manager FSM states.
package axi_fifo_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ADDR,
        RD_DATA,
        RD_FLUSH
    } rd_mgr_state_t;

endpackage

// File: rtl/axi_rd_beat_buf.sv
// One-entry beat register with valid/ready toward the local consumer.
// 'ready' tells the producer a load this cycle will not overwrite unread data.
module axi_rd_beat_buf #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  s_axi_clk,
    input  logic                  s_axi_resetn,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  last,
    output logic                  valid,
    input  logic                  take
);

    // Empty, or being drained this cycle, so a new beat can land.
    assign ready = !valid || take;

    // Load wins over drain so a same-cycle consume+load keeps valid high.
    always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
        if (!s_axi_resetn) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            last  <= load_last;
        end else if (valid && take) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_mgr_read_interface.sv
// AXI read manager: one AR per local command, R beats forwarded through a
// one-entry buffer, done pulse with sticky response/length error flags.
module axi_mgr_read_interface
    import axi_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  s_axi_clk,
    input  logic                  s_axi_resetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [LEN_WIDTH-1:0]  m_axi_arlen,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  done,
    output logic                  err_resp,
    output logic                  err_len
);

    rd_mgr_state_t         state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH:0]    beat_cnt;   // one extra bit: reaches len+1 without wrapping
    logic                  err_resp_q, err_len_q;
    logic                  buf_ready, cmd_hs, r_hs, at_len;

    assign cmd_hs = cmd_valid && cmd_ready;
    assign r_hs   = m_axi_rvalid && m_axi_rready;
    assign at_len = (beat_cnt == {1'b0, len_q});

    // AR fields come straight from the latched command, so they hold until arready.
    assign m_axi_araddr = addr_q;
    assign m_axi_arlen  = len_q;

    // Error flags are only meaningful alongside done.
    assign err_resp = done && err_resp_q;
    assign err_len  = done && err_len_q;

    // State register.
    always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
        if (!s_axi_resetn) state <= RD_IDLE;
        else               state <= state_nxt;
    end

    // Next-state and channel handshake outputs.
    always_comb begin
        state_nxt     = state;
        cmd_ready     = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        done          = 1'b0;
        case (state)
            RD_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = RD_ADDR;
            end
            RD_ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_nxt = RD_DATA;
            end
            RD_DATA: begin
                m_axi_rready = buf_ready;
                // Either the expected count or an early RLAST closes collection.
                if (r_hs && (at_len || m_axi_rlast)) state_nxt = RD_FLUSH;
            end
            RD_FLUSH: begin
                if (!out_valid) begin
                    done      = 1'b1;
                    state_nxt = RD_IDLE;
                end
            end
            default: state_nxt = RD_IDLE;
        endcase
    end

    // Command latch, beat counter and per-transaction sticky error flags.
    always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
        if (!s_axi_resetn) begin
            addr_q     <= '0;
            len_q      <= '0;
            beat_cnt   <= '0;
            err_resp_q <= 1'b0;
            err_len_q  <= 1'b0;
        end else if (cmd_hs) begin
            addr_q     <= cmd_addr;
            len_q      <= cmd_len;
            beat_cnt   <= '0;
            err_resp_q <= 1'b0;
            err_len_q  <= 1'b0;
        end else if (r_hs) begin
            beat_cnt <= beat_cnt + {{LEN_WIDTH{1'b0}}, 1'b1};
            if (m_axi_rresp != RESP_OKAY) err_resp_q <= 1'b1;
            // RLAST must coincide exactly with the len-th beat.
            if (m_axi_rlast != at_len)    err_len_q  <= 1'b1;
        end
    end

    axi_rd_beat_buf #(.DATA_WIDTH(DATA_WIDTH)) u_beat_buf (
        .s_axi_clk    (s_axi_clk),
        .s_axi_resetn (s_axi_resetn),
        .load         (r_hs),
        .load_data    (m_axi_rdata),
        .load_last    (at_len),
        .ready        (buf_ready),
        .data         (out_data),
        .last         (out_last),
        .valid        (out_valid),
        .take         (out_ready)
    );

endmodule

// File: tb/tb_axi_mgr_read_interface.sv
// Directed bench for the AXI read manager: a table of transactions driven by a
// cycle-level subordinate/consumer model, plus a hand-written mid-burst reset.
module tb_axi_mgr_read_interface;

    logic       s_axi_clk = 1'b0;
    logic       s_axi_resetn;
    logic       cmd_valid, cmd_ready;
    logic [7:0] cmd_addr, cmd_len;
    logic [7:0] m_axi_araddr, m_axi_arlen;
    logic       m_axi_arvalid, m_axi_arready;
    logic [7:0] m_axi_rdata;
    logic [1:0] m_axi_rresp;
    logic       m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic [7:0] out_data;
    logic       out_last, out_valid, out_ready;
    logic       done, err_resp, err_len;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 s_axi_clk = ~s_axi_clk;

    axi_mgr_read_interface #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .LEN_WIDTH(8)) dut (
        .s_axi_clk     (s_axi_clk),
        .s_axi_resetn  (s_axi_resetn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .out_data      (out_data),
        .out_last      (out_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .done          (done),
        .err_resp      (err_resp),
        .err_len       (err_len)
    );

    // One directed transaction: command, subordinate behaviour, consumer pattern, expectations.
    typedef struct {
        logic [7:0] addr;
        logic [7:0] len;
        int         nbeats;     // position of RLAST is nbeats-1
        int         err_beat;   // beat carrying a non-OKAY response, -1 for none
        logic [1:0] err_code;
        int         stall;      // arready held low for this many arvalid cycles
        int         mode;       // 0: out_ready always 1, 1: out_ready toggles
        logic [7:0] data_base;  // beat i carries data_base + i
        logic       exp_err_resp;
        logic       exp_err_len;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        cmd_valid     = 1'b0;
        cmd_addr      = '0;
        cmd_len       = '0;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axi_rlast   = 1'b0;
        out_ready     = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready,     1);
        check({tag, "_arvalid"},   m_axi_arvalid, 0);
        check({tag, "_rready"},    m_axi_rready,  0);
        check({tag, "_out_valid"}, out_valid,     0);
        check({tag, "_out_last"},  out_last,      0);
        check({tag, "_out_data"},  out_data,      0);
        check({tag, "_done"},      done,          0);
        check({tag, "_err_resp"},  err_resp,      0);
        check({tag, "_err_len"},   err_len,       0);
        check({tag, "_araddr"},    m_axi_araddr,  0);
        check({tag, "_arlen"},     m_axi_arlen,   0);
    endtask

    task automatic run_txn(input vec_t v, input int id);
        int         to_send, sent, got, ar_wait;
        bit         ar_done, fin, prev_stall;
        logic [7:0] prev_data;
        logic       prev_last;
        to_send    = (v.nbeats < int'(v.len) + 1) ? v.nbeats : int'(v.len) + 1;
        sent       = 0;
        got        = 0;
        ar_wait    = 0;
        ar_done    = 0;
        fin        = 0;
        prev_stall = 0;
        prev_data  = '0;
        prev_last  = 1'b0;

        @(negedge s_axi_clk);
        cmd_valid = 1'b1;
        cmd_addr  = v.addr;
        cmd_len   = v.len;
        #1;
        check($sformatf("v%0d_cmd_ready", id), cmd_ready, 1);

        for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
            @(negedge s_axi_clk);
            cmd_valid     = 1'b0;
            m_axi_arready = !ar_done && (ar_wait >= v.stall);
            m_axi_rvalid  = ar_done && (sent < to_send);
            m_axi_rdata   = v.data_base + 8'(sent);
            m_axi_rlast   = (sent == v.nbeats - 1);
            m_axi_rresp   = (sent == v.err_beat) ? v.err_code : 2'b00;
            out_ready     = (v.mode == 0) ? 1'b1 : (cyc % 2 == 0);
            #1;
            if (!ar_done) begin
                check($sformatf("v%0d_rready_before_ar", id), m_axi_rready, 0);
                if (m_axi_arvalid) begin
                    check($sformatf("v%0d_araddr", id), m_axi_araddr, v.addr);
                    check($sformatf("v%0d_arlen", id),  m_axi_arlen,  v.len);
                end
            end
            if (v.mode == 0 && ar_done && sent < to_send)
                check($sformatf("v%0d_rready_held", id), m_axi_rready, 1);
            if (prev_stall) begin
                check($sformatf("v%0d_hold_valid", id), out_valid, 1);
                check($sformatf("v%0d_hold_data", id),  out_data,  prev_data);
                check($sformatf("v%0d_hold_last", id),  out_last,  prev_last);
            end
            if (out_valid && !out_ready)
                check($sformatf("v%0d_rready_backpressure", id), m_axi_rready, 0);
            if (out_valid && out_ready) begin
                check($sformatf("v%0d_beat%0d_data", id, got), out_data, v.data_base + 8'(got));
                check($sformatf("v%0d_beat%0d_last", id, got), out_last, got == int'(v.len));
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (m_axi_rvalid && m_axi_rready) sent++;
            if (m_axi_arvalid && m_axi_arready) ar_done = 1;
            else if (m_axi_arvalid) ar_wait++;
            if (done) begin
                check($sformatf("v%0d_beats_delivered", id), got, to_send);
                check($sformatf("v%0d_err_resp", id), err_resp, v.exp_err_resp);
                check($sformatf("v%0d_err_len", id),  err_len,  v.exp_err_len);
                fin = 1;
            end
        end
        if (!fin) begin
            n_checks++;
            n_fail++;
            $display("FAIL v%0d_done_timeout: got no done expected done within 100 cycles", id);
        end

        idle_inputs();
        @(negedge s_axi_clk);
        #1;
        check($sformatf("v%0d_done_pulse", id), done, 0);
        check($sformatf("v%0d_idle_after", id), cmd_ready, 1);
    endtask

    initial begin
        //        addr   len  nb  eb  code   stall mode base   eresp elen
        vecs[0] = '{8'h10, 8'd0, 1, -1, 2'b00, 0, 0, 8'hA5, 1'b0, 1'b0}; // single beat
        vecs[1] = '{8'h20, 8'd3, 4, -1, 2'b00, 0, 0, 8'h01, 1'b0, 1'b0}; // burst of 4
        vecs[2] = '{8'h30, 8'd3, 4, -1, 2'b00, 0, 1, 8'h30, 1'b0, 1'b0}; // backpressure
        vecs[3] = '{8'h44, 8'd2, 3, -1, 2'b00, 5, 0, 8'h50, 1'b0, 1'b0}; // AR stall
        vecs[4] = '{8'h60, 8'd3, 3,  2, 2'b10, 0, 0, 8'h70, 1'b1, 1'b1}; // SLVERR + early rlast
        vecs[5] = '{8'h61, 8'd1, 2, -1, 2'b00, 0, 1, 8'h80, 1'b0, 1'b0}; // clean after errors
        vecs[6] = '{8'h62, 8'd1, 4,  0, 2'b11, 1, 0, 8'h90, 1'b1, 1'b1}; // DECERR + missing rlast
        vecs[7] = '{8'hFF, 8'd2, 1, -1, 2'b00, 0, 1, 8'hC0, 1'b0, 1'b1}; // rlast on first beat

        idle_inputs();
        s_axi_resetn = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge s_axi_clk);
        @(negedge s_axi_clk);
        s_axi_resetn = 1'b1;

        for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

        // Reset in the middle of a 4-beat burst after two beats are taken.
        @(negedge s_axi_clk);
        cmd_valid = 1'b1;
        cmd_addr  = 8'h22;
        cmd_len   = 8'd3;
        @(negedge s_axi_clk);
        cmd_valid     = 1'b0;
        m_axi_arready = 1'b1;
        #1;
        check("midrst_arvalid", m_axi_arvalid, 1);
        @(negedge s_axi_clk);
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b1;
        m_axi_rdata   = 8'h11;
        @(negedge s_axi_clk);
        m_axi_rdata   = 8'h12;
        #1;
        check("midrst_out_valid", out_valid, 1);
        @(negedge s_axi_clk);
        m_axi_rvalid  = 1'b0;
        s_axi_resetn  = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge s_axi_clk);
        s_axi_resetn = 1'b1;
        #1;
        check("midrst_cmd_ready_release", cmd_ready, 1);
        run_txn(vecs[1], 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_mgr_read_interface.md
# axi_mgr_read_interface

AXI manager-side read engine: accepts a read command (start address, beat count) from local logic, issues one AR request, collects the R beats and hands them to local logic through a one-entry output buffer with valid/ready. It is the initiator counterpart of the FIFO subordinate read port and drives that port's AR/R channels in the FIFO testbench and in bridge top levels. Reports completion, response errors and beat-count/RLAST mismatches per transaction.

## Interface
- DATA_WIDTH, 8, R data width
- ADDR_WIDTH, 8, AR address width
- LEN_WIDTH, 8, width of beat count field (beats−1, AXI ARLEN style)
- s_axi_clk  in  1  clock
- s_axi_resetn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  local read command valid
- cmd_ready  out  1  engine idle, command accepted on valid&&ready
- cmd_addr  in  ADDR_WIDTH  start address
- cmd_len  in  LEN_WIDTH  beats−1
- m_axi_araddr  out  ADDR_WIDTH  AR address
- m_axi_arlen  out  LEN_WIDTH  AR length (beats−1)
- m_axi_arvalid  out  1  AR valid
- m_axi_arready  in  1  AR ready
- m_axi_rdata  in  DATA_WIDTH  R data
- m_axi_rresp  in  2  R response
- m_axi_rlast  in  1  R last beat
- m_axi_rvalid  in  1  R valid
- m_axi_rready  out  1  R ready
- out_data  out  DATA_WIDTH  delivered beat
- out_last  out  1  delivered beat is final beat of transaction
- out_valid  out  1  out_data valid
- out_ready  in  1  local consumer ready
- done  out  1  one-cycle pulse, transaction complete
- err_resp  out  1  valid with done: any beat had rresp != OKAY
- err_len  out  1  valid with done: RLAST position disagreed with cmd_len

## Operation
- States: IDLE, ADDR, DATA, FLUSH (state enum in package).
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready latch addr/len, clear beat counter and error flags, go ADDR.
- ADDR: m_axi_arvalid=1, araddr/arlen from latched command, stable until m_axi_arready; on handshake go DATA.
- DATA: m_axi_rready = !out_valid || out_ready. Each R handshake loads out_data, out_last=(count==len), sets out_valid, increments count (LEN_WIDTH+1 bits, no wrap).
  - rresp != 2'b00 on any beat -> err_resp sticky for the transaction.
  - rlast=1 with count<len, or rlast=0 with count==len -> err_len sticky.
  - Beat with count==len or rlast=1 ends collection: go FLUSH. Early rlast ends transaction short; beats beyond len are not accepted (rready=0 outside DATA).
- FLUSH: wait until out_valid clears (out_valid&&out_ready or already empty); then done=1 for one cycle, err_* valid that cycle, go IDLE.
- out buffer: out_valid cleared on out_valid&&out_ready unless reloaded same cycle (simultaneous consume and load keeps out_valid=1 with new data).
- Reset (any time, incl. mid-burst): state IDLE, cmd_ready=1, arvalid=0, rready=0, out_valid=0, out_last=0, out_data=0, done=0, err_resp=0, err_len=0, araddr=0, arlen=0. In-flight beats discarded.

## Timing
- cmd handshake at edge N -> arvalid=1 from cycle N+1.
- arready in first arvalid cycle -> rready may assert next cycle.
- R handshake at edge M -> out_valid=1 from M+1 (1-cycle latency); full throughput 1 beat/cycle when out_ready held high.
- Last beat consumed at edge K -> done at K+1; cmd_ready at K+2 (IDLE).
- out_valid/out_data/out_last held stable while out_valid&&!out_ready.
- arvalid never deasserts before arready.

## Structure
- Package axi_fifo_pkg: RESP_OKAY/EXOKAY/SLVERR/DECERR constants, rd_mgr_state_t enum.
- Sub-module axi_rd_beat_buf: one-entry data/last register with valid/ready, provides load-enable/ready to the FSM.

## Test plan
- Single beat: cmd addr=0x10 len=0, arready immediate, rdata=0xA5 rlast=1 rresp=0 -> out_data=0xA5 out_last=1, done pulse, err_resp=0 err_len=0.
- Burst of 4, out_ready=1: rdata 0x01..0x04 back-to-back -> four consecutive out_valid cycles, out_last only on 0x04, rready never drops.
- Backpressure: len=3, out_ready toggles 1/0 -> rready=0 whenever out_valid&&!out_ready, no beat lost or duplicated, order preserved.
- AR stall: arready low 5 cycles -> arvalid, araddr, arlen stable all 5 cycles, no rready before AR handshake.
- Errors: len=3, beat 2 rresp=2'b10, rlast on beat 2 -> three beats delivered, done with err_resp=1 err_len=1; next command starts clean with flags 0.
- Reset mid-burst after 2 of 4 beats -> all outputs at reset values, cmd_ready=1 after release, new command completes normally.
